// File: rtl/pp_shift_accumulator.sv
// pp_shift_accumulator
//   Serial shift-add combiner for multiplier partial products. Each group is
//   NUM_PP beats. Beat k is zero-extended, shifted left by k*SHIFT and added
//   into a running sum. After the last beat the OUT_W-bit result is held on a
//   valid/ready output until the downstream stage takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   partial-product beat valid
//   in_ready   block can accept a beat (ACC state, not in reset)
//   in_data    partial product, unsigned, IN_W bits
//   out_valid  result valid (OUT state)
//   out_ready  downstream accepts result
//   out_data   accumulated result, OUT_W bits, kept after the handshake
//   busy       a group is part-way through or a result is pending
//   ovf        (PP_SHIFT_ACC_OVF_EN only) a bit at or above OUT_W was nonzero
//
// Optional feature macro: PP_SHIFT_ACC_OVF_EN
module pp_shift_accumulator #(
  parameter int IN_W   = 36,
  parameter int SHIFT  = 12,
  parameter int NUM_PP = 2,
  parameter int OUT_W  = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
`ifdef PP_SHIFT_ACC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W  = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
  // One spare bit above the widest shifted operand holds the carry.
  localparam int FULL_W = IN_W + SHIFT*(NUM_PP-1) + 1;

  typedef enum logic {ACC, OUT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   idx;
  logic [OUT_W-1:0]   acc;

  logic               accept;
  logic               last;
  logic [FULL_W-1:0]  ext;
  logic [FULL_W-1:0]  sum;
  logic [OUT_W-1:0]   acc_next;

  assign in_ready = (state == ACC) && !rst;
  assign busy     = (idx != '0) || (state == OUT);
  assign accept   = in_valid && in_ready;
  assign last     = (idx == CNT_W'(NUM_PP-1));

  always_comb begin
    ext      = FULL_W'(in_data) << (SHIFT * int'(idx));
    // First beat of a group starts from zero rather than the stale sum.
    sum      = ((idx == '0) ? '0 : FULL_W'(acc)) + ext;
    acc_next = OUT_W'(sum);
  end

`ifdef PP_SHIFT_ACC_OVF_EN
  logic ovf_acc;
  logic ovf_next;

  // Sticky over the group: any truncated bit, from a shifted operand or a carry.
  always_comb begin
    ovf_next = ((idx == '0) ? 1'b0 : ovf_acc) | (|sum[FULL_W-1:OUT_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_acc <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      ovf_acc <= ovf_next;
      if (last)            ovf <= ovf_next;
      else if (idx == '0)  ovf <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= acc_next;
            if (last) begin
              idx       <= '0;
              state     <= OUT;
              out_valid <= 1'b1;
              out_data  <= acc_next;
            end else begin
              idx <= idx + CNT_W'(1);
            end
          end
        end
        OUT: begin
          // in_valid ignored here; in_ready is low until back in ACC.
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_shift_accumulator.sv
module tb_pp_shift_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  int          n_assert = 0;
  int          n_fail   = 0;

  // Default configuration: 36-bit beats, 12-bit shift, 2 beats, 48-bit result
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [35:0] a_in_data;
  logic [47:0] a_out_data;
  // Three-beat configuration: 24-bit beats, 12-bit shift, 48-bit result
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [23:0] b_in_data;
  logic [47:0] b_out_data;
`ifdef PP_SHIFT_ACC_OVF_EN
  logic        a_ovf, b_ovf;
`endif

  always #5 clk = ~clk;

  pp_shift_accumulator dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy)
`ifdef PP_SHIFT_ACC_OVF_EN
    , .ovf(a_ovf)
`endif
  );

  pp_shift_accumulator #(.IN_W(24), .SHIFT(12), .NUM_PP(3), .OUT_W(48)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy)
`ifdef PP_SHIFT_ACC_OVF_EN
    , .ovf(b_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [35:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic a_take();
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'bx; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'bx; b_in_data = '0; b_out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_out_data", {16'd0, a_out_data}, 64'd0);
    chk("rst_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_b_out_data", {16'd0, b_out_data}, 64'd0);
`ifdef PP_SHIFT_ACC_OVF_EN
    chk("rst_ovf", {63'd0, a_ovf}, 64'd0);
`endif
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {63'd0, a_in_ready}, 64'd1);

    // 1 + (1<<12)
    a_beat(36'h1);
    chk("t1_busy_mid", {63'd0, a_busy}, 64'd1);
    chk("t1_no_out_mid", {63'd0, a_out_valid}, 64'd0);
    a_beat(36'h1);
    chk("t1_out_valid", {63'd0, a_out_valid}, 64'd1);
    chk("t1_out_data", {16'd0, a_out_data}, 64'h000000001001);
    chk("t1_in_ready_out", {63'd0, a_in_ready}, 64'd0);
`ifdef PP_SHIFT_ACC_OVF_EN
    chk("t1_ovf", {63'd0, a_ovf}, 64'd0);
`endif

    // Backpressure with in_valid asserted (must be ignored in OUT)
    a_in_valid = 1'b1; a_in_data = 36'h7;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", {63'd0, a_out_valid}, 64'd1);
      chk("bp_out_data", {16'd0, a_out_data}, 64'h000000001001);
      chk("bp_in_ready", {63'd0, a_in_ready}, 64'd0);
    end
    a_in_valid = 1'b0;
    a_take();
    chk("rel_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("rel_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rel_busy", {63'd0, a_busy}, 64'd0);
    chk("rel_data_kept", {16'd0, a_out_data}, 64'h000000001001);

    // All-ones beats: sum exceeds 48 bits, truncated
    a_beat(36'hF_FFFF_FFFF);
    a_beat(36'hF_FFFF_FFFF);
    chk("t2_out_data", {16'd0, a_out_data}, 64'h000F_FFFF_EFFF);
`ifdef PP_SHIFT_ACC_OVF_EN
    chk("t2_ovf", {63'd0, a_ovf}, 64'd1);
`endif
    a_take();

    // Idle gaps between beats: 0x10 + (0x20<<12)
    a_beat(36'h10);
`ifdef PP_SHIFT_ACC_OVF_EN
    chk("gap_ovf_cleared", {63'd0, a_ovf}, 64'd0);
`endif
    step();
    step();
    chk("gap_busy", {63'd0, a_busy}, 64'd1);
    chk("gap_no_out", {63'd0, a_out_valid}, 64'd0);
    a_beat(36'h20);
    chk("gap_out_valid", {63'd0, a_out_valid}, 64'd1);
    chk("gap_out_data", {16'd0, a_out_data}, 64'h000000020010);
    a_take();

    // Reset mid-group discards the first beat
    a_beat(36'h5);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", {63'd0, a_busy}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    rst = 1'b0;
    a_beat(36'h2);
    chk("mid_rst_no_out", {63'd0, a_out_valid}, 64'd0);
    a_beat(36'h3);
    chk("mid_rst_out_data", {16'd0, a_out_data}, 64'h000000003002);
`ifdef PP_SHIFT_ACC_OVF_EN
    chk("mid_rst_ovf", {63'd0, a_ovf}, 64'd0);
`endif
    a_take();

    // Three-beat instance: 1 + (1<<12) + (1<<24)
    b_in_valid = 1'b1; b_in_data = 24'h1;
    step();
    chk("b_busy1", {63'd0, b_busy}, 64'd1);
    step();
    chk("b_busy2", {63'd0, b_busy}, 64'd1);
    chk("b_no_out2", {63'd0, b_out_valid}, 64'd0);
    step();
    b_in_valid = 1'b0;
    chk("b_out_valid", {63'd0, b_out_valid}, 64'd1);
    chk("b_out_data", {16'd0, b_out_data}, 64'h000001001001);
    chk("b_busy_out", {63'd0, b_busy}, 64'd1);
`ifdef PP_SHIFT_ACC_OVF_EN
    chk("b_ovf", {63'd0, b_ovf}, 64'd0);
`endif
    step();
    chk("b_hold_busy", {63'd0, b_busy}, 64'd1);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    chk("b_busy_done", {63'd0, b_busy}, 64'd0);
    chk("b_in_ready_done", {63'd0, b_in_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
